axi_sim_console_slave: RTL

//  AXI write-channel responder for the simulation SoC: it is the slave end of the CPU BIU write port.

---
 rtl/axi_sim_console_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_sim_console_slave.sv
// AXI write-channel slave for the sim SoC: console character FIFO
// plus sticky pass/fail flags from the sim-control register.
module axi_sim_console_slave #(
  parameter logic [39:0] CONSOLE_ADDR = 40'h0090000000,
  parameter logic [39:0] CTRL_ADDR    = 40'h0090000010,
  parameter logic [63:0] PASS_MAGIC   = 64'h0000000444333222,
  parameter logic [63:0] FAIL_MAGIC   = 64'h0000002382348720,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         awvalid,
  output logic         awready,
  input  logic [39:0]  awaddr,
  input  logic [3:0]   awlen,
  input  logic [7:0]   awid,
  input  logic         wvalid,
  output logic         wready,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         wlast,
  output logic         bvalid,
  input  logic         bready,
  output logic [1:0]   bresp,
  output logic [7:0]   bid,
  output logic         char_vld,
  input  logic         char_rdy,
  output logic [7:0]   char_data,
  output logic         sim_pass,
  output logic         sim_fail
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        con_q;
  logic        ctl_q;
  logic        err_q;
  logic        first_q;
  logic [7:0]  id_q;

  logic        con_dec;
  logic        ctl_dec;
  logic        aw_hs;
  logic        w_hs;
  logic        stall;

  logic [3:0]  lane;
  logic [7:0]  push_byte;
  logic        push;
  logic        pop;
  logic [63:0] ctl_val;
  logic        ctl_we;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] rd_nxt;
  logic [PW:0] count;
  logic        full;
  logic [7:0]  head_nxt;

  logic        unused_ok;

  assign unused_ok = ^awaddr[3:0];

  assign con_dec = awaddr[39:4] == CONSOLE_ADDR[39:4];
  assign ctl_dec = awaddr[39:4] == CTRL_ADDR[39:4];

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Only the character-carrying beat waits for FIFO space
  assign stall = first_q && con_q && !err_q && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (awvalid) state_nxt = DATA;
      end
      DATA: begin
        if (w_hs && wlast) state_nxt = RESP;
      end
      RESP: begin
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    unique case (state)
      IDLE: awready = 1'b1;
      DATA: wready  = !stall;
      RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  assign bid = id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      con_q   <= 1'b0;
      ctl_q   <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      id_q    <= 8'h00;
    end else if (aw_hs) begin
      con_q   <= con_dec;
      ctl_q   <= ctl_dec;
      err_q   <= con_dec && (awlen != 4'd0);
      first_q <= 1'b1;
      id_q    <= awid;
    end else if (w_hs) begin
      first_q <= 1'b0;
    end
  end

  always_comb begin
    lane = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (wstrb[i]) lane = 4'(i);
    end
  end

  assign push_byte = wdata[{lane, 3'b000} +: 8];

  assign push = w_hs && first_q && con_q &&
                !err_q && (wstrb != 16'h0);
  assign pop  = char_vld && char_rdy;

  assign ctl_val = (|wstrb[7:0]) ? wdata[63:0]
                                 : wdata[127:64];
  assign ctl_we  = w_hs && first_q && ctl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_pass <= 1'b0;
      sim_fail <= 1'b0;
    end else if (ctl_we) begin
      if (ctl_val == PASS_MAGIC) sim_pass <= 1'b1;
      if (ctl_val == FAIL_MAGIC) sim_fail <= 1'b1;
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign full     = count == (PW+1)'(FIFO_DEPTH);
  assign char_vld = wr_ptr != rd_ptr;
  assign rd_nxt   = rd_ptr + (PW+1)'(pop);

  // Head register tracks the entry at the post-pop read pointer
  always_comb begin
    head_nxt = char_data;
    if (count == (PW+1)'(pop)) begin
      if (push) head_nxt = push_byte;
    end else begin
      head_nxt = mem[rd_nxt[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      char_data <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_nxt;
      char_data <= head_nxt;
    end
  end

endmodule
